// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_chain register pipeline.
package pipe_pkg;

    // Largest supported pipeline depth.
    localparam int MAX_STAGES = 8;

    // Width of a stage index as reported on the forwarding ports.
    localparam int STAGE_IDX_W = 3;

    // Width of the occupancy counter; holds 0..MAX_STAGES.
    localparam int OCC_W = 4;

    // Population count over a padded valid vector.
    function automatic logic [OCC_W-1:0] countOnes(input logic [MAX_STAGES-1:0] bits);
        logic [OCC_W-1:0] total;
        total = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            total = total + OCC_W'(bits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit plus payload (data, rd, wen).
// When accept is high the slot takes whatever is offered; an empty offer
// turns the slot into a bubble holding the nop payload. Otherwise it holds.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                RD_W       = 5,
    parameter logic [DATA_W-1:0] RESET_DATA = 32'h13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic              loadValid,
    input  logic [DATA_W-1:0] loadData,
    input  logic [RD_W-1:0]   loadRd,
    input  logic              loadWen,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [RD_W-1:0]   rd,
    output logic              wen
);

    // Slot register: reset to a bubble, load on accept, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= RESET_DATA;
            rd    <= '0;
            wen   <= 1'b0;
        end else if (accept) begin
            valid <= loadValid;
            if (loadValid) begin
                data <= loadData;
                rd   <= loadRd;
                wen  <= loadWen;
            end else begin
                data <= RESET_DATA;
                rd   <= '0;
                wen  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// Elastic register pipeline with per-stage flush, bubble collapse and
// register-forwarding lookup ports. Stage 0 is youngest, STAGES-1 the tail.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready may depend combinationally on downstream ready; valid
// never depends on ready. in_ready reflects whether stage 0 can take an
// entry this cycle; out_valid is the tail's valid masked by its flush bit.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                STAGES     = 3,
    parameter int                RD_W       = 5,
    parameter int                NSRC       = 2,
    parameter logic [DATA_W-1:0] RESET_DATA = 32'h13
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [RD_W-1:0]               in_rd,
    input  logic                          in_wen,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [RD_W-1:0]               out_rd,
    output logic                          out_wen,
    input  logic [STAGES-1:0]             flush,
    input  logic [NSRC*RD_W-1:0]          src_addr,
    output logic [NSRC-1:0]               fwd_hit,
    output logic [NSRC*STAGE_IDX_W-1:0]   fwd_stage,
    output logic [NSRC*DATA_W-1:0]        fwd_data,
    output logic [OCC_W-1:0]              occupancy
);

    logic [STAGES-1:0]     stValid;
    logic [STAGES-1:0]     stWen;
    logic [DATA_W-1:0]     stData [STAGES];
    logic [RD_W-1:0]       stRd   [STAGES];

    logic [STAGES-1:0]     liveValid;   // valid and not being killed this cycle
    logic [STAGES-1:0]     accept;      // stage loads its input at the edge
    logic [STAGES-1:0]     loadValid;   // validity of what each stage would load
    logic [STAGES-1:0]     nextValid;
    logic [MAX_STAGES-1:0] nextValidPad;
    logic                  tailMove;

    // Accept chain, evaluated from the tail backwards so a bubble anywhere
    // downstream lets every live entry upstream of it advance.
    always_comb begin
        liveValid = stValid & ~flush;
        tailMove  = liveValid[STAGES-1] & out_ready;
        accept    = '0;
        accept[STAGES-1] = ~stValid[STAGES-1] | flush[STAGES-1] | tailMove;
        for (int i = STAGES - 2; i >= 0; i--) begin
            accept[i] = ~stValid[i] | flush[i] | (liveValid[i] & accept[i+1]);
        end
        loadValid    = '0;
        loadValid[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            loadValid[i] = liveValid[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            nextValid[i] = accept[i] ? loadValid[i] : stValid[i];
        end
        nextValidPad = '0;
        nextValidPad[STAGES-1:0] = nextValid;
    end

    assign in_ready  = accept[0];
    assign out_valid = liveValid[STAGES-1];
    assign out_data  = stData[STAGES-1];
    assign out_rd    = stRd[STAGES-1];
    assign out_wen   = stWen[STAGES-1];

    for (genvar s = 0; s < STAGES; s++) begin : gStage
        logic [DATA_W-1:0] srcData;
        logic [RD_W-1:0]   srcRd;
        logic              srcWen;

        if (s == 0) begin : gHead
            assign srcData = in_data;
            assign srcRd   = in_rd;
            assign srcWen  = in_wen;
        end else begin : gBody
            assign srcData = stData[s-1];
            assign srcRd   = stRd[s-1];
            assign srcWen  = stWen[s-1];
        end

        pipe_stage #(
            .DATA_W     (DATA_W),
            .RD_W       (RD_W),
            .RESET_DATA (RESET_DATA)
        ) uStage (
            .clk       (clk),
            .reset     (reset),
            .accept    (accept[s]),
            .loadValid (loadValid[s]),
            .loadData  (srcData),
            .loadRd    (srcRd),
            .loadWen   (srcWen),
            .valid     (stValid[s]),
            .data      (stData[s]),
            .rd        (stRd[s]),
            .wen       (stWen[s])
        );
    end

    // Occupancy register tracks the number of valid stages after each edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= countOnes(nextValidPad);
        end
    end

    // Forwarding lookup per source port: youngest live writer of a nonzero
    // register wins. Only current stage contents are searched.
    for (genvar k = 0; k < NSRC; k++) begin : gFwd
        logic [RD_W-1:0]        addr;
        logic                   hit;
        logic [STAGE_IDX_W-1:0] idx;
        logic [DATA_W-1:0]      dat;

        assign addr = src_addr[k*RD_W +: RD_W];

        // Priority search from the tail down so the lowest index is kept.
        always_comb begin
            hit = 1'b0;
            idx = '0;
            dat = '0;
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (liveValid[i] && stWen[i] && (stRd[i] == addr) && (addr != '0)) begin
                    hit = 1'b1;
                    idx = STAGE_IDX_W'(i);
                    dat = stData[i];
                end
            end
        end

        assign fwd_hit[k]                              = hit;
        assign fwd_stage[k*STAGE_IDX_W +: STAGE_IDX_W] = idx;
        assign fwd_data[k*DATA_W +: DATA_W]            = dat;
    end

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain with STAGES=3, NSRC=2.
module tb_pipe_chain;

    localparam int DATA_W = 32;
    localparam int STAGES = 3;
    localparam int RD_W   = 5;
    localparam int NSRC   = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data = '0;
    logic [RD_W-1:0]      in_rd = '0;
    logic                 in_wen = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DATA_W-1:0]    out_data;
    logic [RD_W-1:0]      out_rd;
    logic                 out_wen;
    logic [STAGES-1:0]    flush = '0;
    logic [NSRC*RD_W-1:0] src_addr = '0;
    logic [NSRC-1:0]      fwd_hit;
    logic [NSRC*3-1:0]    fwd_stage;
    logic [NSRC*DATA_W-1:0] fwd_data;
    logic [3:0]           occupancy;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    pipe_chain #(
        .DATA_W     (DATA_W),
        .STAGES     (STAGES),
        .RD_W       (RD_W),
        .NSRC       (NSRC),
        .RESET_DATA (32'h13)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_wen   (out_wen),
        .flush     (flush),
        .src_addr  (src_addr),
        .fwd_hit   (fwd_hit),
        .fwd_stage (fwd_stage),
        .fwd_data  (fwd_data),
        .occupancy (occupancy)
    );

    // advance past the next rising edge; inputs change 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one entry onto the input side
    task automatic drive_in(input logic v, input logic [DATA_W-1:0] d,
                            input logic [RD_W-1:0] r, input logic w);
        in_valid = v;
        in_data  = d;
        in_rd    = r;
        in_wen   = w;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_in(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (fwd_hit !== 2'b00) begin errors++; $display("FAIL reset_fwd_hit got %b exp 00", fwd_hit); end
        checks++; if (out_data !== 32'h13) begin errors++; $display("FAIL reset_out_data got %h exp 00000013", out_data); end
        checks++; if (out_rd !== 5'd0 || out_wen !== 1'b0) begin errors++; $display("FAIL reset_out_rd_wen got %0d/%b exp 0/0", out_rd, out_wen); end
        tick();
    endtask

    task automatic test_stream();
        bit exp_v;
        int exp_occ;
        out_ready = 1'b1;
        for (int n = 0; n < 15; n++) begin
            drive_in(n < 10, 32'h100 + n, 5'(n + 1), 1'b0);
            @(negedge clk);
            exp_v = (n >= 3) && (n < 13);
            exp_occ = 0;
            for (int j = 0; j < 10; j++) begin
                if (n >= j + 1 && n <= j + 3) exp_occ++;
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc %0d got %b exp 1", n, in_ready); end
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_out_valid cyc %0d got %b exp %b", n, out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (out_data !== 32'h100 + n - 3) begin errors++; $display("FAIL stream_out_data cyc %0d got %h exp %h", n, out_data, 32'h100 + n - 3); end
            end
            checks++; if (occupancy !== 4'(exp_occ)) begin errors++; $display("FAIL stream_occ cyc %0d got %0d exp %0d", n, occupancy, exp_occ); end
            tick();
        end
        drive_in(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_backpressure();
        int sent;
        int got;
        logic [DATA_W-1:0] e;
        sent = 0;
        got = 0;
        exp_q.delete();
        for (int n = 0; n < 20; n++) begin
            out_ready = (n >= 5);
            drive_in(sent < 5, 32'h200 + sent, '0, 1'b0);
            @(negedge clk);
            if (n == 3 || n == 4) begin
                checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL bp_occ cyc %0d got %0d exp 3", n, occupancy); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", n, in_ready); end
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b exp 1", n, out_valid); end
                checks++; if (out_data !== 32'h200) begin errors++; $display("FAIL bp_tail_hold cyc %0d got %h exp 00000200", n, out_data); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_drain_extra got %h exp none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin errors++; $display("FAIL bp_drain_order got %h exp %h", out_data, e); end
                end
                got++;
            end
            tick();
        end
        drive_in(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        checks++; if (got !== 5) begin errors++; $display("FAIL bp_drain_count got %0d exp 5", got); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL bp_final_occ got %0d exp 0", occupancy); end
        tick();
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        src_addr = {5'd0, 5'd9};
        drive_in(1'b1, 32'h3A, 5'd1, 1'b0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_a_ready got %b exp 1", in_ready); end
        tick();
        drive_in(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        drive_in(1'b1, 32'h3B, 5'd9, 1'b1);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_b_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h3A) begin errors++; $display("FAIL bub_a_tail got %b/%h exp 1/0000003a", out_valid, out_data); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL bub_occ1 got %0d exp 1", occupancy); end
        tick();
        drive_in(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_collapse_ready got %b exp 1", in_ready); end
        checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL bub_occ2 got %0d exp 2", occupancy); end
        checks++; if (fwd_hit[0] !== 1'b1 || fwd_stage[2:0] !== 3'd0) begin errors++; $display("FAIL bub_b_stage0 got %b/%0d exp 1/0", fwd_hit[0], fwd_stage[2:0]); end
        tick();
        @(negedge clk);
        checks++; if (fwd_hit[0] !== 1'b1 || fwd_stage[2:0] !== 3'd1) begin errors++; $display("FAIL bub_b_stage1 got %b/%0d exp 1/1", fwd_hit[0], fwd_stage[2:0]); end
        checks++; if (fwd_data[31:0] !== 32'h3B) begin errors++; $display("FAIL bub_b_data got %h exp 0000003b", fwd_data[31:0]); end
        checks++; if (out_data !== 32'h3A) begin errors++; $display("FAIL bub_a_held got %h exp 0000003a", out_data); end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h3A) begin errors++; $display("FAIL bub_out_a got %b/%h exp 1/0000003a", out_valid, out_data); end
        tick();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h3B) begin errors++; $display("FAIL bub_out_b got %b/%h exp 1/0000003b", out_valid, out_data); end
        tick();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL bub_empty got %b/%0d exp 0/0", out_valid, occupancy); end
        src_addr = '0;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        drive_in(1'b1, 32'h55, 5'd5, 1'b1);
        tick();
        drive_in(1'b1, 32'h66, 5'd6, 1'b1);
        tick();
        drive_in(1'b0, '0, '0, 1'b0);
        flush = 3'b010;
        src_addr = {5'd6, 5'd5};
        @(negedge clk);
        checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL fl_occ_pre got %0d exp 2", occupancy); end
        checks++; if (fwd_hit !== 2'b10) begin errors++; $display("FAIL fl_fwd_hit got %b exp 10", fwd_hit); end
        checks++; if (fwd_stage[5:3] !== 3'd0) begin errors++; $display("FAIL fl_y_stage0 got %0d exp 0", fwd_stage[5:3]); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_valid0 got %b exp 0", out_valid); end
        tick();
        flush = '0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_valid1 got %b exp 0", out_valid); end
        checks++; if (fwd_hit !== 2'b10 || fwd_stage[5:3] !== 3'd1) begin errors++; $display("FAIL fl_y_stage1 got %b/%0d exp 10/1", fwd_hit, fwd_stage[5:3]); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL fl_occ_post got %0d exp 1", occupancy); end
        tick();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h66 || out_rd !== 5'd6) begin errors++; $display("FAIL fl_out_y got %b/%h/%0d exp 1/00000066/6", out_valid, out_data, out_rd); end
        tick();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL fl_empty got %b/%0d exp 0/0", out_valid, occupancy); end
        src_addr = '0;
        tick();
    endtask

    task automatic test_forward();
        out_ready = 1'b0;
        drive_in(1'b1, 32'hBB, 5'd7, 1'b1);
        tick();
        drive_in(1'b1, 32'h33, 5'd3, 1'b1);
        tick();
        drive_in(1'b1, 32'hAA, 5'd7, 1'b1);
        tick();
        drive_in(1'b0, '0, '0, 1'b0);
        src_addr = {5'd3, 5'd7};
        @(negedge clk);
        checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL fw_occ got %0d exp 3", occupancy); end
        checks++; if (fwd_hit !== 2'b11) begin errors++; $display("FAIL fw_hit got %b exp 11", fwd_hit); end
        checks++; if (fwd_stage[2:0] !== 3'd0 || fwd_data[31:0] !== 32'hAA) begin errors++; $display("FAIL fw_p0_youngest got %0d/%h exp 0/000000aa", fwd_stage[2:0], fwd_data[31:0]); end
        checks++; if (fwd_stage[5:3] !== 3'd1 || fwd_data[63:32] !== 32'h33) begin errors++; $display("FAIL fw_p1 got %0d/%h exp 1/00000033", fwd_stage[5:3], fwd_data[63:32]); end
        src_addr = {5'd4, 5'd0};
        #1;
        checks++; if (fwd_hit !== 2'b00 || fwd_stage !== 6'd0 || fwd_data !== 64'd0) begin errors++; $display("FAIL fw_miss got %b/%0d/%h exp 00/0/0", fwd_hit, fwd_stage, fwd_data); end
        src_addr = {5'd7, 5'd7};
        flush = 3'b001;
        #1;
        checks++; if (fwd_hit[0] !== 1'b1 || fwd_stage[2:0] !== 3'd2 || fwd_data[31:0] !== 32'hBB) begin errors++; $display("FAIL fw_flush_skip got %b/%0d/%h exp 1/2/000000bb", fwd_hit[0], fwd_stage[2:0], fwd_data[31:0]); end
        flush = '0;
        drive_in(1'b1, 32'hCC, 5'd7, 1'b1);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fw_full_ready got %b exp 0", in_ready); end
        checks++; if (fwd_stage[2:0] !== 3'd0 || fwd_data[31:0] !== 32'hAA) begin errors++; $display("FAIL fw_no_arrival got %0d/%h exp 0/000000aa", fwd_stage[2:0], fwd_data[31:0]); end
        drive_in(1'b0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_midreset();
        @(negedge clk);
        checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL mr_pre_occ got %0d exp 3", occupancy); end
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        flush = 3'b100;
        drive_in(1'b1, 32'hDD, 5'd7, 1'b1);
        tick();
        reset = 1'b0;
        flush = '0;
        drive_in(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL mr_occ got %0d exp 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h13) begin errors++; $display("FAIL mr_out_data got %h exp 00000013", out_data); end
        checks++; if (in_ready !== 1'b1 || fwd_hit !== 2'b00) begin errors++; $display("FAIL mr_ready_fwd got %b/%b exp 1/00", in_ready, fwd_hit); end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_forward();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
